// File: rtl/ps2_key_fifo.sv
// PS/2 set-2 scan-code decoder feeding a small ASCII key-event FIFO.
// Break/extended prefixes, Shift and Caps Lock are resolved here; only printable ASCII, Enter, Backspace and Tab are queued.
module ps2_key_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    scan_code,
    input  logic          scan_valid,
    input  logic          pop,
    input  logic          clr_ovf,
    output logic [7:0]    key_data,
    output logic          key_avail,
    output logic [AW:0]   key_count,
    output logic          overflow
);
    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} dec_state_t;

    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BRK   = 8'hF0;
    localparam logic [7:0] CODE_LSH   = 8'h12;
    localparam logic [7:0] CODE_RSH   = 8'h59;
    localparam logic [7:0] CODE_CAPS  = 8'h58;
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    // Indexed by letter (A..Z) and digit (0..9) so the ASCII value is a plain offset.
    localparam logic [7:0] LETTER_CODES [26] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
        8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
        8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A
    };
    localparam logic [7:0] DIGIT_CODES [10] = '{
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46
    };

    dec_state_t     state_reg;
    logic           lshift_reg;
    logic           rshift_reg;
    logic           caps_reg;

    logic [25:0]    letter_hit;
    logic [9:0]     digit_hit;
    logic           upper;
    logic           map_valid;
    logic [7:0]     map_ascii;
    logic           push_req;

    logic [7:0]     mem [DEPTH];
    logic [AW-1:0]  wr_ptr_reg;
    logic [AW-1:0]  rd_ptr_reg;
    logic [AW:0]    count_reg;
    logic [AW:0]    count_next;
    logic           ovf_reg;
    logic           empty;
    logic           full;
    logic           pop_ok;
    logic           push_ok;
    logic           ovf_event;

    genvar gi;
    generate
        for (gi = 0; gi < 26; gi++) begin : g_letter
            assign letter_hit[gi] = (scan_code == LETTER_CODES[gi]);
        end
        for (gi = 0; gi < 10; gi++) begin : g_digit
            assign digit_hit[gi] = (scan_code == DIGIT_CODES[gi]);
        end
    endgenerate

    assign upper = (lshift_reg | rshift_reg) ^ caps_reg;

    always_comb begin
        map_valid = 1'b0;
        map_ascii = 8'h00;
        for (int i = 0; i < 26; i++) begin
            if (letter_hit[i]) begin
                map_valid = 1'b1;
                map_ascii = (upper ? 8'h41 : 8'h61) + 8'(i);
            end
        end
        for (int i = 0; i < 10; i++) begin
            if (digit_hit[i]) begin
                map_valid = 1'b1;
                map_ascii = 8'h30 + 8'(i);
            end
        end
        case (scan_code)
            8'h29: begin map_valid = 1'b1; map_ascii = 8'h20; end
            8'h5A: begin map_valid = 1'b1; map_ascii = 8'h0D; end
            8'h66: begin map_valid = 1'b1; map_ascii = 8'h08; end
            8'h0D: begin map_valid = 1'b1; map_ascii = 8'h09; end
            default: ;
        endcase
    end

    // Only a plain make byte seen in IDLE can produce a key event.
    assign push_req = scan_valid && (state_reg == IDLE) && (scan_code != CODE_EXT)
                      && (scan_code != CODE_BRK) && map_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            lshift_reg <= 1'b0;
            rshift_reg <= 1'b0;
            caps_reg   <= 1'b0;
        end else if (scan_valid) begin
            unique case (state_reg)
                IDLE: begin
                    if (scan_code == CODE_EXT) begin
                        state_reg <= EXT;
                    end else if (scan_code == CODE_BRK) begin
                        state_reg <= BRK;
                    end else begin
                        if (scan_code == CODE_LSH)  lshift_reg <= 1'b1;
                        if (scan_code == CODE_RSH)  rshift_reg <= 1'b1;
                        if (scan_code == CODE_CAPS) caps_reg   <= ~caps_reg;
                    end
                end
                EXT:     state_reg <= (scan_code == CODE_BRK) ? EXT_BRK : IDLE;
                BRK: begin
                    if (scan_code == CODE_LSH) lshift_reg <= 1'b0;
                    if (scan_code == CODE_RSH) rshift_reg <= 1'b0;
                    state_reg <= IDLE;
                end
                EXT_BRK: state_reg <= IDLE;
            endcase
        end
    end

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == FULL_COUNT);
    assign pop_ok    = pop && !empty;
    // A simultaneous pop frees the slot, so a push at full is then accepted.
    assign push_ok   = push_req && (!full || pop_ok);
    assign ovf_event = push_req && full && !pop_ok;

    always_comb begin
        count_next = count_reg + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= map_ascii;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
            if (ovf_event)    ovf_reg <= 1'b1;
            else if (clr_ovf) ovf_reg <= 1'b0;
        end
    end

    assign key_data  = empty ? 8'h00 : mem[rd_ptr_reg];
    assign key_avail = !empty;
    assign key_count = count_reg;
    assign overflow  = ovf_reg;

endmodule

// File: tb/tb_ps2_key_fifo.sv
// Randomized and directed bench for ps2_key_fifo against a queue-based key-event model.
module tb_ps2_key_fifo;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [7:0]    scan_code = 8'h00;
    logic          scan_valid = 1'b0;
    logic          pop = 1'b0;
    logic          clr_ovf = 1'b0;
    logic [7:0]    key_data;
    logic          key_avail;
    logic [AW:0]   key_count;
    logic          overflow;

    ps2_key_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .scan_code  (scan_code),
        .scan_valid (scan_valid),
        .pop        (pop),
        .clr_ovf    (clr_ovf),
        .key_data   (key_data),
        .key_avail  (key_avail),
        .key_count  (key_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] letters [26] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
        8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
        8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A
    };
    logic [7:0] digits [10] = '{
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46
    };
    logic [7:0] pool [24] = '{
        8'h1C, 8'h32, 8'h21, 8'h45, 8'h16, 8'h29, 8'h5A, 8'h66, 8'h0D, 8'h12,
        8'h59, 8'h58, 8'hE0, 8'hF0, 8'hF0, 8'h75, 8'h1B, 8'h2C, 8'h44, 8'h3D,
        8'h12, 8'h59, 8'h0E, 8'hE0
    };

    // Model: pending prefix flags, modifier flags, and the queue of key events.
    logic [7:0] q [$];
    bit m_ovf, m_e0, m_f0, m_lsh, m_rsh, m_caps;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_map(input logic [7:0] c, input bit up, output logic [7:0] a);
        a = 8'h00;
        for (int i = 0; i < 26; i++)
            if (c == letters[i]) begin a = 8'((up ? 65 : 97) + i); return 1'b1; end
        for (int i = 0; i < 10; i++)
            if (c == digits[i]) begin a = 8'(48 + i); return 1'b1; end
        case (c)
            8'h29: begin a = 8'h20; return 1'b1; end
            8'h5A: begin a = 8'h0D; return 1'b1; end
            8'h66: begin a = 8'h08; return 1'b1; end
            8'h0D: begin a = 8'h09; return 1'b1; end
            default: return 1'b0;
        endcase
    endfunction

    function automatic void model_clear();
        q.delete();
        {m_ovf, m_e0, m_f0, m_lsh, m_rsh, m_caps} = '0;
    endfunction

    function automatic void model_step(input logic [7:0] c, input bit v, input bit p, input bit clr);
        bit do_push = 1'b0;
        bit pop_eff, full;
        logic [7:0] a = 8'h00;
        if (v) begin
            if (c == 8'hE0 && !m_e0 && !m_f0) m_e0 = 1'b1;
            else if (c == 8'hF0 && !m_f0) m_f0 = 1'b1;
            else begin
                if (m_e0) begin
                    // extended keys are never queued
                end else if (m_f0) begin
                    if (c == 8'h12) m_lsh = 1'b0;
                    if (c == 8'h59) m_rsh = 1'b0;
                end else begin
                    do_push = model_map(c, (m_lsh | m_rsh) ^ m_caps, a);
                    if (c == 8'h12) m_lsh = 1'b1;
                    if (c == 8'h59) m_rsh = 1'b1;
                    if (c == 8'h58) m_caps = !m_caps;
                end
                m_e0 = 1'b0;
                m_f0 = 1'b0;
            end
        end
        pop_eff = p && (q.size() > 0);
        full = (q.size() == DEPTH);
        if (pop_eff) void'(q.pop_front());
        if (clr) m_ovf = 1'b0;
        if (do_push) begin
            if (full && !pop_eff) m_ovf = 1'b1;
            else q.push_back(a);
        end
    endfunction

    task automatic cyc(input logic [7:0] c, input bit v, input bit p, input bit clr);
        @(negedge clk);
        #1;
        scan_code = c; scan_valid = v; pop = p; clr_ovf = clr;
        @(posedge clk);
        if (p && q.size() > 0) $display("pop  key=%02h count=%0d", q[0], q.size());
        model_step(c, v, p, clr);
    endtask

    task automatic key(input logic [7:0] c);
        cyc(c, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle_pop(input bit p);
        cyc(8'h00, 1'b0, p, 1'b0);
        #2;
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        #1;
        scan_valid = 1'b0; pop = 1'b0; clr_ovf = 1'b0;
        reset = 1'b0;
        model_clear();
        #1;
        chk("rst_key_data", key_data, 8'h00);
        chk("rst_key_avail", key_avail, 1'b0);
        chk("rst_key_count", key_count, 0);
        chk("rst_overflow", overflow, 1'b0);
        @(posedge clk);
        @(negedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Output check against the model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("key_data", key_data, (q.size() > 0) ? q[0] : 8'h00);
            chk("key_avail", key_avail, q.size() > 0);
            chk("key_count", key_count, q.size());
            chk("overflow", overflow, m_ovf);
        end
    end

    initial begin
        logic [7:0] hand_exp [16];
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk); #1 reset = 1'b1;

        // 'a' press and release
        key(8'h1C); key(8'hF0); key(8'h1C); idle_pop(1'b0);
        chk("t1_count", key_count, 1);
        chk("t1_data", key_data, 8'h61);
        idle_pop(1'b1);
        chk("t1_avail_after_pop", key_avail, 1'b0);
        chk("t1_data_after_pop", key_data, 8'h00);

        // shift then release
        key(8'h12); key(8'h1C); key(8'hF0); key(8'h12); key(8'h1C); idle_pop(1'b0);
        chk("t2_first", key_data, 8'h41);
        idle_pop(1'b1);
        chk("t2_second", key_data, 8'h61);
        idle_pop(1'b1);

        // same with caps on
        key(8'h58); key(8'hF0); key(8'h58);
        key(8'h12); key(8'h1C); key(8'hF0); key(8'h12); key(8'h1C); idle_pop(1'b0);
        chk("t2c_first", key_data, 8'h61);
        idle_pop(1'b1);
        chk("t2c_second", key_data, 8'h41);
        idle_pop(1'b1);
        key(8'h58); key(8'hF0); key(8'h58);

        // extended key ignored, Enter queued
        key(8'hE0); key(8'h75); key(8'hE0); key(8'hF0); key(8'h75); key(8'h5A); idle_pop(1'b0);
        chk("t3_count", key_count, 1);
        chk("t3_data", key_data, 8'h0D);
        idle_pop(1'b1);

        // 17 lower-case letters into a 16-deep FIFO
        for (int i = 0; i < 17; i++) begin
            int idx = $urandom_range(25);
            if (i < 16) hand_exp[i] = 8'(97 + idx);
            key(letters[idx]); key(8'hF0); key(letters[idx]);
        end
        idle_pop(1'b0);
        chk("t4_count_full", key_count, 16);
        chk("t4_overflow", overflow, 1'b1);
        for (int i = 0; i < 16; i++) begin
            chk("t4_order", key_data, hand_exp[i]);
            idle_pop(1'b1);
        end
        chk("t4_empty", key_avail, 1'b0);
        cyc(8'h00, 1'b0, 1'b0, 1'b1); #2;
        chk("t4_clr_ovf", overflow, 1'b0);

        // fill with digits, then push+pop pairs at full
        for (int i = 0; i < 16; i++) key(digits[i % 10]);
        idle_pop(1'b0);
        chk("t5_full", key_count, 16);
        chk("t5_head0", key_data, 8'h30);
        for (int i = 0; i < 20; i++) begin
            cyc(8'h1C, 1'b1, 1'b1, 1'b0); #2;
            chk("t5_count_stays", key_count, 16);
            chk("t5_no_ovf", overflow, 1'b0);
            if (i == 0) chk("t5_head1", key_data, 8'h31);
        end
        chk("t5_tail_a", key_data, 8'h61);
        for (int i = 0; i < 16; i++) idle_pop(1'b1);

        // push+pop on empty: pop ignored
        cyc(8'h1C, 1'b1, 1'b1, 1'b0); #2;
        chk("t5_empty_pushpop", key_count, 1);
        idle_pop(1'b1);

        // reset mid-sequence clears prefix and shift
        key(8'h12); key(8'hF0);
        rst_pulse();
        key(8'h1C); idle_pop(1'b0);
        chk("t6_count", key_count, 1);
        chk("t6_data", key_data, 8'h61);
        idle_pop(1'b1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            int pop_pct = (i < 1500) ? 10 : 45;
            cyc(pool[$urandom_range(23)], $urandom_range(99) < 55,
                $urandom_range(99) < pop_pct, $urandom_range(99) < 4);
            if (i == 1000 || i == 2200) rst_pulse();
        end
        idle_pop(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
